// File: rtl/boot_pkg.sv
// Shared types and defaults for the instruction-RAM boot loader.
package boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FAULT
    } boot_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/watchdog_counter.sv
// Idle-cycle watchdog: counts while enabled, clears on demand, flags the
// cycle whose count would reach TIMEOUT-1.
module watchdog_counter
    import boot_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 2);

    logic [W-1:0] value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (count) begin
            value <= value + 1'b1;
        end
    end

    // Expiry is flagged one cycle early so the FSM leaves on the edge where
    // the count would reach TIMEOUT-1.
    assign expired = count && !clear && (value == LIMIT);

endmodule

// File: rtl/boot_loader.sv
// Streams LEN words into instruction RAM, then releases the core from reset;
// an idle-timeout or oversize LEN parks the loader in FAULT.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned SIZE       = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH:0]   LEN,
    input  logic                  S_VALID,
    input  logic [SIZE-1:0]       S_DATA,
    output logic                  S_READY,
    output logic [ADDR_WIDTH-1:0] ADDR_W,
    output logic                  ENABLE_W,
    output logic [SIZE-1:0]       Q_W,
    output logic                  CORE_RESET_N,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    boot_state_t           state, state_next;
    boot_state_t           start_target;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  xfer;
    logic                  last_xfer;
    logic                  enter_load;
    logic                  enter_run;
    logic                  wd_clear;
    logic                  wd_count;
    logic                  wd_expired;

    assign S_READY   = (state == ST_LOAD) && (cnt < len_q);
    assign xfer      = S_VALID && S_READY;
    assign last_xfer = xfer && ((cnt + 1'b1) == len_q);
    assign BUSY      = (state == ST_LOAD);
    assign ERROR     = (state == ST_FAULT);
    assign wd_clear  = (state != ST_LOAD) || xfer;
    assign wd_count  = (state == ST_LOAD);

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (LEN == '0) begin
            start_target = ST_RUN;
        end else if (LEN <= MAX_LEN) begin
            start_target = ST_LOAD;
        end else begin
            start_target = ST_FAULT;
        end

        case (state)
            ST_IDLE, ST_RUN, ST_FAULT: begin
                if (START) begin
                    state_next = start_target;
                end
            end
            ST_LOAD: begin
                // A transfer always beats a coincident timeout.
                if (xfer) begin
                    if (last_xfer) begin
                        state_next = ST_RUN;
                    end
                end else if (wd_expired) begin
                    state_next = ST_FAULT;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        enter_load = (state != ST_LOAD) && (state_next == ST_LOAD);
        enter_run  = (state_next == ST_RUN) &&
                     ((state != ST_RUN) || (START && (LEN == '0)));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt          <= '0;
            len_q        <= '0;
            ADDR_W       <= '0;
            Q_W          <= '0;
            ENABLE_W     <= 1'b0;
            DONE         <= 1'b0;
            CORE_RESET_N <= 1'b0;
        end else begin
            ENABLE_W <= xfer;
            if (xfer) begin
                ADDR_W <= cnt[ADDR_WIDTH-1:0];
                Q_W    <= S_DATA;
            end
            if (enter_load) begin
                cnt   <= '0;
                len_q <= LEN;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
            DONE <= enter_run;
            // Release the core only once the final write has landed.
            CORE_RESET_N <= (state == ST_RUN) && (state_next == ST_RUN);
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a reference model and write scoreboard.
module tb_boot_loader;

    localparam int AW  = 10;
    localparam int SZ  = 32;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          START = 1'b0;
    logic [AW:0]   LEN = '0;
    logic          S_VALID = 1'b0;
    logic [SZ-1:0] S_DATA = '0;
    logic          S_READY;
    logic [AW-1:0] ADDR_W;
    logic          ENABLE_W;
    logic [SZ-1:0] Q_W;
    logic          CORE_RESET_N;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;

    boot_loader #(
        .ADDR_WIDTH (AW),
        .SIZE       (SZ),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .LEN          (LEN),
        .S_VALID      (S_VALID),
        .S_DATA       (S_DATA),
        .S_READY      (S_READY),
        .ADDR_W       (ADDR_W),
        .ENABLE_W     (ENABLE_W),
        .Q_W          (Q_W),
        .CORE_RESET_N (CORE_RESET_N),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERROR        (ERROR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 idle, 1 load, 2 run, 3 fault.
    int            ms = 0;
    logic [AW:0]   m_cnt = '0;
    logic [AW:0]   m_len = '0;
    int            m_idle = 0;
    logic [AW+SZ-1:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int ns;
        bit rdy, xf, exp_done, exp_crn;
        logic [AW+SZ-1:0] e;
        rdy = (ms == 1) && (m_cnt < m_len);
        chk("s_ready", S_READY, rdy);
        xf = S_VALID && rdy;
        ns = ms;
        if (ms == 1) begin
            if (xf) begin
                if (m_cnt + 1 == m_len) ns = 2;
            end else if (m_idle + 1 == TMO - 1) begin
                ns = 3;
            end
        end else if (START) begin
            ns = (LEN == 0) ? 2 : ((LEN <= 1024) ? 1 : 3);
        end
        exp_done = (ns == 2) && ((ms != 2) || (START && LEN == 0));
        exp_crn  = (ms == 2) && (ns == 2);
        if (xf) sb.push_back({m_cnt[AW-1:0], S_DATA});
        if (ms != 1 && ns == 1) begin
            m_cnt = '0; m_len = LEN; m_idle = 0;
        end else if (ms == 1) begin
            if (xf) begin m_cnt = m_cnt + 1; m_idle = 0; end
            else m_idle++;
        end
        ms = ns;
        @(posedge CLK); #1;
        chk("busy", BUSY, ms == 1);
        chk("error", ERROR, ms == 3);
        chk("done", DONE, exp_done);
        chk("core_reset_n", CORE_RESET_N, exp_crn);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("enable_w", ENABLE_W, 1'b1);
            chk("addr_w", ADDR_W, e[AW+SZ-1:SZ]);
            chk("q_w", Q_W, e[SZ-1:0]);
        end else begin
            chk("enable_w_idle", ENABLE_W, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        #1;
        chk("rst_enable_w", ENABLE_W, 1'b0);
        chk("rst_s_ready", S_READY, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_error", ERROR, 1'b0);
        chk("rst_core_reset_n", CORE_RESET_N, 1'b0);
        chk("rst_addr_w", ADDR_W, 0);
        chk("rst_q_w", Q_W, 0);
        #1;
        RESET = 1'b0;
        ms = 0; m_cnt = '0; m_len = '0; m_idle = 0;
        sb.delete();
    endtask

    task automatic begin_load(input int len);
        START = 1'b1;
        LEN   = (AW+1)'(len);
        step();
        START = 1'b0;
    endtask

    initial begin
        int k;
        #1;
        pulse_reset();
        step(); step();

        // Four words back to back, core released after the last write.
        S_VALID = 1'b1;
        S_DATA  = 32'h11;
        begin_load(4);
        for (int i = 0; i < 4; i++) begin
            S_DATA = 32'h11 * (i + 1);
            step();
        end
        S_VALID = 1'b0;
        step(); step();
        chk("run_core_released", CORE_RESET_N, 1'b1);

        // Reload from RUN: core goes back into reset the next cycle.
        begin_load(2);
        chk("reload_core_reset", CORE_RESET_N, 1'b0);
        S_VALID = 1'b1;
        S_DATA = 32'hA1; step();
        S_DATA = 32'hA2; step();
        S_VALID = 1'b0;
        step(); step();

        // Gapped stream; a START during LOAD is ignored.
        begin_load(3);
        S_VALID = 1'b1; S_DATA = 32'h31; step();
        S_VALID = 1'b0; START = 1'b1; LEN = 11'd1; step();
        START = 1'b0;
        S_VALID = 1'b1; S_DATA = 32'h32; step();
        S_VALID = 1'b0; step();
        S_VALID = 1'b1; S_DATA = 32'h33; step();
        S_VALID = 1'b0;
        step(); step();

        // Idle timeout after one word, then recovery.
        begin_load(2);
        S_VALID = 1'b1; S_DATA = 32'h77; step();
        S_VALID = 1'b0;
        k = 0;
        while (ERROR !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("timeout_idle_cycles", k, 7);
        chk("fault_core_reset_n", CORE_RESET_N, 1'b0);
        begin_load(1);
        chk("fault_error_cleared", ERROR, 1'b0);
        S_VALID = 1'b1; S_DATA = 32'h55; step();
        S_VALID = 1'b0;
        step(); step();

        // LEN boundaries: zero, oversize, and the full RAM.
        pulse_reset();
        begin_load(0);
        step();
        begin_load(1025);
        step();
        begin_load(1024);
        S_VALID = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            S_DATA = $urandom;
            step();
        end
        S_VALID = 1'b0;
        step(); step();

        // Reset during a load aborts further writes.
        begin_load(5);
        S_VALID = 1'b1;
        S_DATA = 32'hC1; step();
        S_DATA = 32'hC2; step();
        pulse_reset();
        S_DATA = 32'hC3;
        step(); step(); step();
        S_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of the instruction RAM write port.
REQ-002 SHALL have parameter SIZE, default 32, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles between stream words.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port START  input  1  begin a load; sampled in IDLE, RUN, FAULT.
REQ-007 SHALL have port LEN  input  ADDR_WIDTH+1  number of words to load; sampled with START.
REQ-008 SHALL have port S_VALID  input  1  stream word valid.
REQ-009 SHALL have port S_DATA  input  SIZE  stream word.
REQ-010 SHALL have port S_READY  output  1  loader accepts a word.
REQ-011 SHALL have port ADDR_W  output  ADDR_WIDTH  RAM write address.
REQ-012 SHALL have port ENABLE_W  output  1  RAM write enable.
REQ-013 SHALL have port Q_W  output  SIZE  RAM write data.
REQ-014 SHALL have port CORE_RESET_N  output  1  active-low reset to the core.
REQ-015 SHALL have port BUSY  output  1  high in LOAD.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse on entering RUN.
REQ-017 SHALL have port ERROR  output  1  high in FAULT.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, FAULT.
REQ-019 IDLE: START with 0<LEN<=2^ADDR_WIDTH -> LOAD; LEN==0 -> RUN; LEN>2^ADDR_WIDTH -> FAULT; no START -> stay.
REQ-020 Entering LOAD SHALL latch LEN, clear word counter and write address to 0, and clear the idle counter.
REQ-021 S_READY SHALL be 1 only in LOAD, and only while the counter is below the latched LEN.
REQ-022 A transfer SHALL occur on a cycle with S_VALID && S_READY.
REQ-023 Each transfer SHALL register ADDR_W=counter, Q_W=S_DATA, ENABLE_W=1 for exactly the next cycle (1-cycle latency), then increment the counter.
REQ-024 ENABLE_W SHALL be 0 in every cycle not immediately following a transfer.
REQ-025 When the transfer making counter==LEN occurs, the FSM SHALL go LOAD -> RUN on that edge; the final write completes in the first RUN cycle.
REQ-026 The idle counter SHALL increment each LOAD cycle without a transfer, clear on every transfer, and on reaching TIMEOUT-1 without a transfer move LOAD -> FAULT.
REQ-027 If the last transfer and the timeout coincide, the transfer SHALL win (-> RUN).
REQ-028 CORE_RESET_N SHALL be registered: 1 only in RUN from the cycle after the final write, 0 in IDLE, LOAD, FAULT.
REQ-029 DONE SHALL pulse for one cycle on every entry into RUN, including LEN==0.
REQ-030 In RUN, START SHALL re-enter LOAD (same LEN rules as IDLE), driving CORE_RESET_N=0 from the next cycle.
REQ-031 FAULT SHALL hold ERROR=1, CORE_RESET_N=0, S_READY=0; only START leaves it, with IDLE's LEN rules, and ERROR clears on exit.
REQ-032 Address arithmetic SHALL be ADDR_WIDTH bits; the counter is ADDR_WIDTH+1 bits so LEN=2^ADDR_WIDTH writes addresses 0..2^ADDR_WIDTH-1 without wrap.
REQ-033 START while in LOAD SHALL be ignored.

Reset
REQ-034 RESET high SHALL immediately force IDLE, counters 0, ADDR_W=0, Q_W=0, ENABLE_W=0, S_READY=0, BUSY=0, DONE=0, ERROR=0, CORE_RESET_N=0.
REQ-035 RESET asserted mid-LOAD SHALL abort the load with no further writes; the words already written remain in RAM.

Structure
REQ-036 Package boot_pkg SHALL hold the state enum and the default TIMEOUT constant.
REQ-037 Idle-timeout counting SHALL be the sub-module watchdog_counter (clear, count, expired), instanced once.

Verification
REQ-038 START, LEN=4, S_VALID held high with data 0x11..0x44 -> writes addr 0..3 on consecutive cycles, DONE pulse, CORE_RESET_N=1 the cycle after the last write.
REQ-039 LEN=3, S_VALID toggling 1,0,1,0,1 -> exactly 3 writes at addr 0,1,2 with no gaps in address, then RUN.
REQ-040 TIMEOUT=8, LEN=2, one word then S_VALID=0 -> FAULT 7 idle cycles after the transfer, ERROR=1, CORE_RESET_N=0; then START, LEN=1 -> ERROR clears, load succeeds.
REQ-041 START with LEN=0 -> RUN next cycle, DONE pulse, no writes; START with LEN=1025 (ADDR_WIDTH=10) -> FAULT.
REQ-042 RESET pulsed after 2 of 5 words -> ENABLE_W=0 and S_READY=0 immediately, IDLE, CORE_RESET_N=0.
REQ-043 In RUN, START with LEN=2 -> CORE_RESET_N=0 next cycle, 2 writes, DONE pulse, CORE_RESET_N=1.
